// File: rtl/seq_restoring_divider.sv
`default_nettype none
// ============================================================================
// Module      : seq_restoring_divider
// Description : Multi-cycle unsigned restoring divider. One trial subtraction
//               per clock through a (WIDTH+1)-bit ripple subtract chain.
//               start/done handshake; results held until the next operation
//               completes.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_restoring_divider #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] C_LAST_ITER = CNT_W'(WIDTH - 1);

    // Encoding chosen so busy and done each come straight from one flop bit.
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // Partial remainder. The restoring algorithm keeps it below the divisor,
    // so the top bit of the (WIDTH+1)-bit remainder is always zero and is
    // not stored.
    logic [WIDTH-1:0] r_p;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_divisor;
    logic [CNT_W-1:0] r_cnt;

    logic [WIDTH:0]   w_a;
    logic [WIDTH:0]   w_b;
    logic [WIDTH:0]   w_t;
    logic [WIDTH:0]   w_c;
    logic [WIDTH-1:0] w_p_next;
    logic [WIDTH-1:0] w_q_next;
    logic             w_last;

    // Trial subtraction a - b computed as a + ~b + 1.
    assign w_a    = {r_p, r_q[WIDTH-1]};
    assign w_b    = ~{1'b0, r_divisor};
    assign w_c[0] = 1'b1;

    generate
        for (genvar i = 0; i <= WIDTH; i++) begin : g_ripple
            assign w_t[i] = w_a[i] ^ w_b[i] ^ w_c[i];
            if (i < WIDTH) begin : g_carry
                assign w_c[i+1] = (w_a[i] & w_b[i]) | (w_c[i] & (w_a[i] ^ w_b[i]));
            end
        end
    endgenerate

    // Select restored or subtracted remainder and shift in the quotient bit.
    always_comb begin
        w_p_next = w_a[WIDTH-1:0];
        w_q_next = {r_q[WIDTH-2:0], 1'b0};
        if (!w_t[WIDTH]) begin
            w_p_next = w_t[WIDTH-1:0];
            w_q_next = {r_q[WIDTH-2:0], 1'b1};
        end
    end

    assign w_last = (r_cnt == C_LAST_ITER);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic and status outputs.
    always_comb begin
        w_state_next = r_state;
        busy         = r_state[0];
        done         = r_state[1];
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = (divisor == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Datapath: operand capture, iteration, and result registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_p         <= '0;
            r_q         <= '0;
            r_divisor   <= '0;
            r_cnt       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_p       <= '0;
                        r_q       <= dividend;
                        r_divisor <= divisor;
                        r_cnt     <= '0;
                        if (divisor == '0) begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    r_p   <= w_p_next;
                    r_q   <= w_q_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        quotient    <= w_q_next;
                        remainder   <= w_p_next;
                        div_by_zero <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seq_restoring_divider.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_restoring_divider
// Description : Directed self-checking bench for seq_restoring_divider at
//               WIDTH=4 and WIDTH=8.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_restoring_divider;

    logic       clk = 1'b0;
    logic       reset = 1'b1;

    logic       start4 = 1'b0;
    logic [3:0] dvd4 = '0;
    logic [3:0] dvs4 = '0;
    logic       busy4, done4, dbz4;
    logic [3:0] quot4, rem4;

    logic       start8 = 1'b0;
    logic [7:0] dvd8 = '0;
    logic [7:0] dvs8 = '0;
    logic       busy8, done8, dbz8;
    logic [7:0] quot8, rem8;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    seq_restoring_divider #(.WIDTH(4)) dut4 (
        .clk(clk), .reset(reset), .start(start4), .dividend(dvd4), .divisor(dvs4),
        .busy(busy4), .done(done4), .quotient(quot4), .remainder(rem4), .div_by_zero(dbz4)
    );

    seq_restoring_divider #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .dividend(dvd8), .divisor(dvs8),
        .busy(busy8), .done(done8), .quotient(quot8), .remainder(rem8), .div_by_zero(dbz8)
    );

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One WIDTH=4 operation; lat counts edges from the start edge to done seen.
    task automatic op4(input logic [3:0] a, input logic [3:0] b,
                       output logic [3:0] q, output logic [3:0] r, output logic z,
                       output int lat, output int bc);
        @(negedge clk);
        dvd4 = a; dvs4 = b; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        lat = 1; bc = 0;
        while (!done4 && lat < 40) begin
            if (busy4) bc++;
            @(posedge clk); #1;
            lat++;
        end
        if (!done4) check("op4_timeout", 0, 1);
        check("op4_busy_at_done", busy4, 0);
        q = quot4; r = rem4; z = dbz4;
        @(posedge clk); #1;
        check("op4_done_width", done4, 0);
    endtask

    task automatic op8(input logic [7:0] a, input logic [7:0] b,
                       output logic [7:0] q, output logic [7:0] r, output logic z,
                       output int lat);
        @(negedge clk);
        dvd8 = a; dvs8 = b; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        lat = 1;
        while (!done8 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!done8) check("op8_timeout", 0, 1);
        q = quot8; r = rem8; z = dbz8;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [3:0] q4, r4;
        logic [7:0] q8, r8;
        logic       z;
        int         lat, bc;
        int         seen_done;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy4, 0);
        check("rst_done", done4, 0);
        check("rst_quot", quot4, 0);
        check("rst_rem", rem4, 0);
        check("rst_dbz", dbz4, 0);
        @(negedge clk);
        reset = 1'b0;

        // 13/3
        op4(4'd13, 4'd3, q4, r4, z, lat, bc);
        check("13/3_q", q4, 4);
        check("13/3_r", r4, 1);
        check("13/3_dbz", z, 0);
        check("13/3_lat", lat, 5);
        check("13/3_busy", bc, 4);

        // Assorted directed vectors
        op4(4'd15, 4'd1, q4, r4, z, lat, bc);
        check("15/1_q", q4, 15); check("15/1_r", r4, 0); check("15/1_busy", bc, 4);
        op4(4'd5, 4'd7, q4, r4, z, lat, bc);
        check("5/7_q", q4, 0); check("5/7_r", r4, 5); check("5/7_busy", bc, 4);
        op4(4'd0, 4'd9, q4, r4, z, lat, bc);
        check("0/9_q", q4, 0); check("0/9_r", r4, 0); check("0/9_busy", bc, 4);

        // Divide by zero, then a normal operation clears the flag
        op4(4'd9, 4'd0, q4, r4, z, lat, bc);
        check("9/0_q", q4, 15); check("9/0_r", r4, 9); check("9/0_dbz", z, 1);
        check("9/0_lat", lat, 1); check("9/0_busy", bc, 0);
        op4(4'd6, 4'd2, q4, r4, z, lat, bc);
        check("6/2_q", q4, 3); check("6/2_r", r4, 0); check("6/2_dbz", z, 0);

        // start held high with other operands through RUN and DONE is ignored
        @(negedge clk);
        dvd4 = 4'd14; dvs4 = 4'd4; start4 = 1'b1;
        @(posedge clk); #1;
        dvd4 = 4'd1; dvs4 = 4'd1;
        lat = 1;
        while (!done4 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("14/4_lat", lat, 5);
        check("14/4_q", quot4, 3);
        check("14/4_r", rem4, 2);
        @(posedge clk); #1;
        start4 = 1'b0;
        check("ign_busy", busy4, 0);
        check("ign_done", done4, 0);
        repeat (3) @(posedge clk);
        #1;
        check("hold_q", quot4, 3);
        check("hold_r", rem4, 2);
        check("hold_busy", busy4, 0);
        // Outputs still hold while the next operation runs
        @(negedge clk);
        dvd4 = 4'd7; dvs4 = 4'd7; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        @(posedge clk); #1;
        check("hold_run_q", quot4, 3);
        check("hold_run_r", rem4, 2);
        repeat (3) @(posedge clk);
        #1;
        check("7/7_done", done4, 1);
        check("7/7_q", quot4, 1);
        check("7/7_r", rem4, 0);
        @(posedge clk); #1;

        // Asynchronous reset in the middle of RUN
        @(negedge clk);
        dvd4 = 4'd11; dvs4 = 4'd2; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("arst_busy", busy4, 0);
        check("arst_done", done4, 0);
        check("arst_q", quot4, 0);
        check("arst_r", rem4, 0);
        check("arst_dbz", dbz4, 0);
        @(negedge clk);
        reset = 1'b0;
        seen_done = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (done4) seen_done++;
        end
        check("arst_no_done", seen_done, 0);
        op4(4'd11, 4'd2, q4, r4, z, lat, bc);
        check("11/2_q", q4, 5); check("11/2_r", r4, 1); check("11/2_lat", lat, 5);

        // WIDTH=8 spot check
        op8(8'd255, 8'd16, q8, r8, z, lat);
        check("255/16_q", q8, 15);
        check("255/16_r", r8, 15);
        check("255/16_lat", lat, 9);

        // WIDTH=8 sampled sweep against an integer reference
        for (int a = 0; a < 256; a += 7) begin
            for (int b = 0; b < 256; b += 3) begin
                op8(8'(a), 8'(b), q8, r8, z, lat);
                if (b == 0) begin
                    check("sw_q_dz", q8, 255);
                    check("sw_r_dz", r8, a);
                    check("sw_dbz_dz", z, 1);
                end else begin
                    check("sw_q", q8, a / b);
                    check("sw_r", r8, a % b);
                    check("sw_dbz", z, 0);
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
